// File: rtl/axi_sram_slave_pkg.sv
// axi_sram_slave_pkg: AXI channel types, response codes and FSM states for the SRAM responder
package axi_sram_slave_pkg;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef struct packed {
    logic [3:0] id;
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0] strb;
    logic last;
  } axi_w_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic user;
  } axi_b_t;
  typedef struct packed {
    logic [3:0] id;
    logic [31:0] data;
    logic [1:0] resp;
    logic last;
    logic user;
  } axi_r_t;
  typedef struct packed {
    axi_ax_t aw;
    logic aw_valid;
    axi_w_t w;
    logic w_valid;
    logic b_ready;
    axi_ax_t ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    axi_b_t b;
    logic r_valid;
    axi_r_t r;
  } axi_rsp_t;
endpackage

// File: rtl/axi_sram_slave_mem.sv
// axi_sram_slave_mem: word-wide SRAM, one enabled synchronous read port, one byte-enabled write port
module axi_sram_slave_mem #(
  parameter int unsigned Words = 16384,
  parameter int unsigned AW = 14,
  parameter string InitFile = ""
) (
  input  logic          clk_i,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);
  logic [31:0] mem [Words];
  always_ff @(posedge clk_i) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < 4; i++) if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 INCR-burst responder over on-chip SRAM with independent read/write FSMs
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned MemBytes = 65536,
  parameter string InitFile = ""
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o
);
  localparam int unsigned Words = MemBytes / 4;
  localparam int unsigned AW = Words > 1 ? $clog2(Words) : 1;
  function automatic logic beat_ok(logic [31:0] a, logic size_ok);
    return size_ok && ((a - BaseAddr) < MemBytes);
  endfunction
  function automatic logic [AW-1:0] word_idx(logic [31:0] a);
    return AW'((a - BaseAddr) >> 2);
  endfunction
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic active_q;
  logic [3:0] w_id_q, r_id_q;
  logic [31:0] w_addr_q, r_addr_q, r_next_addr, mem_rdata;
  logic [7:0] w_len_q, w_cnt_q, r_len_q, r_cnt_q;
  logic w_size_ok_q, r_size_ok_q, w_err_q, r_ok_q, r_last_q;
  logic [1:0] b_resp_q, r_resp_q;
  logic aw_ready, ar_ready, w_ready, b_valid, r_valid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_load, r_next_ok, w_ok, w_beat_err;
  logic unused_burst;
  assign unused_burst = ^{axi_req_i.aw.burst, axi_req_i.ar.burst};
  // Readies are held low for the first cycle after reset via active_q
  assign aw_ready = active_q && w_state_q == W_IDLE;
  assign ar_ready = active_q && r_state_q == R_IDLE;
  assign w_ready = w_state_q == W_DATA;
  assign b_valid = w_state_q == W_RESP;
  assign r_valid = r_state_q == R_DATA;
  assign aw_hs = aw_ready && axi_req_i.aw_valid;
  assign w_hs = w_ready && axi_req_i.w_valid;
  assign b_hs = b_valid && axi_req_i.b_ready;
  assign ar_hs = ar_ready && axi_req_i.ar_valid;
  assign r_hs = r_valid && axi_req_i.r_ready;
  assign r_load = ar_hs || (r_hs && !r_last_q);
  assign r_next_addr = r_state_q == R_IDLE ? axi_req_i.ar.addr : r_addr_q;
  assign r_next_ok = beat_ok(r_next_addr, r_state_q == R_IDLE ? axi_req_i.ar.size == AXI_SIZE_WORD : r_size_ok_q);
  assign w_ok = beat_ok(w_addr_q, w_size_ok_q);
  assign w_beat_err = !w_ok || (axi_req_i.w.last != (w_cnt_q == w_len_q));
  always_comb begin
    w_state_d = aw_hs ? W_DATA : (w_hs && axi_req_i.w.last) ? W_RESP : b_hs ? W_IDLE : w_state_q;
    r_state_d = ar_hs ? R_DATA : (r_hs && r_last_q) ? R_IDLE : r_state_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      active_q <= 1'b0;
      w_id_q <= '0;
      r_id_q <= '0;
      b_resp_q <= '0;
      r_resp_q <= '0;
      r_ok_q <= 1'b0;
      r_last_q <= 1'b0;
      w_err_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      active_q <= 1'b1;
      if (aw_hs) begin
        w_id_q <= axi_req_i.aw.id;
        w_addr_q <= axi_req_i.aw.addr;
        w_len_q <= axi_req_i.aw.len;
        w_cnt_q <= '0;
        w_size_ok_q <= axi_req_i.aw.size == AXI_SIZE_WORD;
        w_err_q <= 1'b0;
      end
      if (w_hs) begin
        w_addr_q <= w_addr_q + 32'd4;
        w_cnt_q <= w_cnt_q + 8'd1;
        w_err_q <= w_err_q || w_beat_err;
        if (axi_req_i.w.last) b_resp_q <= (w_err_q || w_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (ar_hs) begin
        r_id_q <= axi_req_i.ar.id;
        r_len_q <= axi_req_i.ar.len;
        r_size_ok_q <= axi_req_i.ar.size == AXI_SIZE_WORD;
        r_cnt_q <= '0;
      end else if (r_load) r_cnt_q <= r_cnt_q + 8'd1;
      if (r_load) begin
        r_addr_q <= r_next_addr + 32'd4;
        r_ok_q <= r_next_ok;
        r_resp_q <= r_next_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        r_last_q <= ar_hs ? axi_req_i.ar.len == 8'd0 : r_cnt_q + 8'd1 == r_len_q;
      end
    end
  end
  axi_sram_slave_mem #(.Words(Words), .AW(AW), .InitFile(InitFile)) u_mem (
    .clk_i(clk_i),
    .re(r_load),
    .raddr(word_idx(r_next_addr)),
    .rdata(mem_rdata),
    .we((w_hs && w_ok) ? axi_req_i.w.strb : 4'h0),
    .waddr(word_idx(w_addr_q)),
    .wdata(axi_req_i.w.data)
  );
  assign axi_rsp_o = '{
    aw_ready: aw_ready,
    ar_ready: ar_ready,
    w_ready: w_ready,
    b_valid: b_valid,
    b: '{id: w_id_q, resp: b_resp_q, user: 1'b0},
    r_valid: r_valid,
    r: '{id: r_id_q, data: r_ok_q ? mem_rdata : 32'h0, resp: r_resp_q, last: r_last_q, user: 1'b0}
  };
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed scenario tests for the AXI SRAM responder
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;
  localparam logic [31:0] B = 32'h8000_0000;
  localparam int unsigned MB = 1024;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  axi_req_t req;
  axi_rsp_t rsp;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  axi_sram_slave #(.BaseAddr(B), .MemBytes(MB), .InitFile("")) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .axi_req_i(req),
    .axi_rsp_o(rsp)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    req.aw = '{id: id, addr: addr, len: len, size: size, burst: 2'b01};
    req.aw_valid = 1'b1;
    for (int i = 0; i < 20 && !rsp.aw_ready; i++) step();
    if (!rsp.aw_ready) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout: aw_ready=%b required 1", rsp.aw_ready);
    end
    step();
    req.aw_valid = 1'b0;
  endtask
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    req.ar = '{id: id, addr: addr, len: len, size: size, burst: 2'b01};
    req.ar_valid = 1'b1;
    for (int i = 0; i < 20 && !rsp.ar_ready; i++) step();
    if (!rsp.ar_ready) begin
      n_tests++; n_fail++;
      $display("FAIL ar_timeout: ar_ready=%b required 1", rsp.ar_ready);
    end
    step();
    req.ar_valid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    req.w = '{data: data, strb: strb, last: last};
    req.w_valid = 1'b1;
    for (int i = 0; i < 20 && !rsp.w_ready; i++) step();
    if (!rsp.w_ready) begin
      n_tests++; n_fail++;
      $display("FAIL w_timeout: w_ready=%b required 1", rsp.w_ready);
    end
    step();
    req.w_valid = 1'b0;
  endtask
  task automatic recv_b(output axi_b_t b);
    req.b_ready = 1'b1;
    for (int i = 0; i < 20 && !rsp.b_valid; i++) step();
    if (!rsp.b_valid) begin
      n_tests++; n_fail++;
      $display("FAIL b_timeout: b_valid=%b required 1", rsp.b_valid);
    end
    b = rsp.b;
    step();
    req.b_ready = 1'b0;
  endtask
  task automatic recv_r(output axi_r_t r);
    req.r_ready = 1'b1;
    for (int i = 0; i < 20 && !rsp.r_valid; i++) step();
    if (!rsp.r_valid) begin
      n_tests++; n_fail++;
      $display("FAIL r_timeout: r_valid=%b required 1", rsp.r_valid);
    end
    r = rsp.r;
    step();
    req.r_ready = 1'b0;
  endtask
  task automatic wr_single(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output axi_b_t b);
    send_aw(4'h1, addr, 8'd0, AXI_SIZE_WORD);
    send_w(data, strb, 1'b1);
    recv_b(b);
  endtask
  task automatic rd_single(input logic [31:0] addr, output axi_r_t r);
    send_ar(4'h1, addr, 8'd0, AXI_SIZE_WORD);
    recv_r(r);
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    req = '0;
    step();
    step();
    n_tests++;
    if ({rsp.aw_ready, rsp.ar_ready, rsp.w_ready, rsp.b_valid, rsp.r_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b required 00000", {rsp.aw_ready, rsp.ar_ready, rsp.w_ready, rsp.b_valid, rsp.r_valid});
    end
    n_tests++;
    if (rsp.b !== '0 || rsp.r !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: b=%h r=%h required 0", rsp.b, rsp.r);
    end
    rst_ni = 1'b1;
    step();
    n_tests++;
    if (rsp.aw_ready !== 1'b1 || rsp.ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: aw_ready=%b ar_ready=%b required 1 1", rsp.aw_ready, rsp.ar_ready);
    end
  endtask
  task automatic test_single();
    axi_b_t b;
    axi_r_t r;
    send_aw(4'h5, B + 32'h10, 8'd0, AXI_SIZE_WORD);
    send_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    recv_b(b);
    n_tests++;
    if (b.id !== 4'h5 || b.resp !== AXI_RESP_OKAY) begin
      n_fail++;
      $display("FAIL single_b: id=%h resp=%b required 5 00", b.id, b.resp);
    end
    send_ar(4'h3, B + 32'h10, 8'd0, AXI_SIZE_WORD);
    n_tests++;
    if (rsp.r_valid !== 1'b1 || rsp.r.data !== 32'hDEAD_BEEF || rsp.r.last !== 1'b1 || rsp.r.id !== 4'h3 || rsp.r.resp !== AXI_RESP_OKAY) begin
      n_fail++;
      $display("FAIL single_r: valid=%b data=%h last=%b id=%h resp=%b required 1 deadbeef 1 3 00", rsp.r_valid, rsp.r.data, rsp.r.last, rsp.r.id, rsp.r.resp);
    end
    recv_r(r);
    n_tests++;
    if (rsp.r_valid !== 1'b0 || rsp.ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: r_valid=%b ar_ready=%b required 0 1", rsp.r_valid, rsp.ar_ready);
    end
  endtask
  task automatic test_burst();
    axi_b_t b;
    int beat;
    send_aw(4'h2, B + 32'h100, 8'd15, AXI_SIZE_WORD);
    for (int i = 0; i < 16; i++) send_w(32'hA000_0000 + i, 4'hF, i == 15);
    recv_b(b);
    n_tests++;
    if (b.id !== 4'h2 || b.resp !== AXI_RESP_OKAY) begin
      n_fail++;
      $display("FAIL burst_b: id=%h resp=%b required 2 00", b.id, b.resp);
    end
    send_ar(4'h7, B + 32'h100, 8'd15, AXI_SIZE_WORD);
    beat = 0;
    for (int c = 0; c < 64 && beat < 16; c++) begin
      req.r_ready = c[0];
      n_tests++;
      if (rsp.r_valid !== 1'b1 || rsp.r.data !== 32'hA000_0000 + beat || rsp.r.last !== (beat == 15) || rsp.r.id !== 4'h7) begin
        n_fail++;
        $display("FAIL burst_beat%0d: valid=%b data=%h last=%b id=%h required 1 %h %b 7", beat, rsp.r_valid, rsp.r.data, rsp.r.last, rsp.r.id, 32'hA000_0000 + beat, beat == 15);
      end
      if (req.r_ready) beat++;
      step();
    end
    req.r_ready = 1'b0;
    n_tests++;
    if (beat != 16 || rsp.r_valid !== 1'b0 || rsp.ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_end: beats=%0d r_valid=%b ar_ready=%b required 16 0 1", beat, rsp.r_valid, rsp.ar_ready);
    end
  endtask
  task automatic test_strobes();
    axi_b_t b;
    axi_r_t r;
    wr_single(B + 32'h20, 32'hFFFF_FFFF, 4'hF, b);
    wr_single(B + 32'h20, 32'h1122_3344, 4'b0101, b);
    rd_single(B + 32'h20, r);
    n_tests++;
    if (r.data !== 32'hFF22_FF44 || r.resp !== AXI_RESP_OKAY) begin
      n_fail++;
      $display("FAIL strobes: data=%h resp=%b required ff22ff44 00", r.data, r.resp);
    end
  endtask
  task automatic test_out_of_range();
    axi_b_t b;
    axi_r_t r;
    logic [31:0] exp_d [4];
    logic [1:0] exp_r [4];
    exp_d = '{32'h55AA_0001, 32'h55AA_0002, 32'h0, 32'h0};
    exp_r = '{AXI_RESP_OKAY, AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_SLVERR};
    send_aw(4'h1, B + MB - 8, 8'd1, AXI_SIZE_WORD);
    send_w(32'h55AA_0001, 4'hF, 1'b0);
    send_w(32'h55AA_0002, 4'hF, 1'b1);
    recv_b(b);
    n_tests++;
    if (b.resp !== AXI_RESP_OKAY) begin
      n_fail++;
      $display("FAIL oor_edge_write: resp=%b required 00", b.resp);
    end
    send_ar(4'h4, B + MB - 8, 8'd3, AXI_SIZE_WORD);
    for (int i = 0; i < 4; i++) begin
      recv_r(r);
      n_tests++;
      if (r.data !== exp_d[i] || r.resp !== exp_r[i] || r.last !== (i == 3)) begin
        n_fail++;
        $display("FAIL oor_read_beat%0d: data=%h resp=%b last=%b required %h %b %b", i, r.data, r.resp, r.last, exp_d[i], exp_r[i], i == 3);
      end
    end
    wr_single(B, 32'hCAFE_F00D, 4'hF, b);
    wr_single(B + MB, 32'h1234_5678, 4'hF, b);
    n_tests++;
    if (b.resp !== AXI_RESP_SLVERR) begin
      n_fail++;
      $display("FAIL oor_write_resp: resp=%b required 10", b.resp);
    end
    rd_single(B, r);
    n_tests++;
    if (r.data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL oor_write_nomod: data=%h required cafef00d", r.data);
    end
  endtask
  task automatic test_protocol();
    axi_b_t b;
    axi_r_t r;
    send_aw(4'h9, B + 32'h40, 8'd3, AXI_SIZE_WORD);
    send_w(32'h1, 4'hF, 1'b0);
    send_w(32'h2, 4'hF, 1'b1);
    recv_b(b);
    n_tests++;
    if (b.id !== 4'h9 || b.resp !== AXI_RESP_SLVERR) begin
      n_fail++;
      $display("FAIL early_last: id=%h resp=%b required 9 10", b.id, b.resp);
    end
    send_aw(4'hA, B + 32'h44, 8'd0, AXI_SIZE_WORD);
    send_w(32'h3, 4'hF, 1'b0);
    send_w(32'h4, 4'hF, 1'b1);
    recv_b(b);
    n_tests++;
    if (b.id !== 4'hA || b.resp !== AXI_RESP_SLVERR) begin
      n_fail++;
      $display("FAIL late_last: id=%h resp=%b required a 10", b.id, b.resp);
    end
    wr_single(B + 32'h48, 32'h5, 4'hF, b);
    n_tests++;
    if (b.resp !== AXI_RESP_OKAY) begin
      n_fail++;
      $display("FAIL err_cleared: resp=%b required 00", b.resp);
    end
    send_ar(4'h6, B + 32'h100, 8'd1, 3'b001);
    for (int i = 0; i < 2; i++) begin
      recv_r(r);
      n_tests++;
      if (r.resp !== AXI_RESP_SLVERR || r.data !== 32'h0 || r.last !== (i == 1) || r.id !== 4'h6) begin
        n_fail++;
        $display("FAIL bad_size_beat%0d: resp=%b data=%h last=%b id=%h required 10 0 %b 6", i, r.resp, r.data, r.last, r.id, i == 1);
      end
    end
  endtask
  task automatic test_reset_mid();
    axi_r_t r;
    send_ar(4'h1, B + 32'h100, 8'd7, AXI_SIZE_WORD);
    for (int i = 0; i < 3; i++) recv_r(r);
    n_tests++;
    if (r.data !== 32'hA000_0002) begin
      n_fail++;
      $display("FAIL mid_pre: data=%h required a0000002", r.data);
    end
    rst_ni = 1'b0;
    step();
    n_tests++;
    if (rsp.r_valid !== 1'b0 || rsp.ar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: r_valid=%b ar_ready=%b required 0 0", rsp.r_valid, rsp.ar_ready);
    end
    rst_ni = 1'b1;
    step();
    n_tests++;
    if (rsp.ar_ready !== 1'b1 || rsp.r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release: ar_ready=%b r_valid=%b required 1 0", rsp.ar_ready, rsp.r_valid);
    end
    rd_single(B + 32'h104, r);
    n_tests++;
    if (r.data !== 32'hA000_0001) begin
      n_fail++;
      $display("FAIL mid_mem_kept: data=%h required a0000001", r.data);
    end
  endtask
  task automatic test_concurrent();
    axi_b_t b;
    axi_r_t r;
    wr_single(B + 32'h80, 32'h0BAD_F00D, 4'hF, b);
    send_aw(4'h3, B + 32'h80, 8'd0, AXI_SIZE_WORD);
    req.w = '{data: 32'h600D_CAFE, strb: 4'hF, last: 1'b1};
    req.w_valid = 1'b1;
    req.ar = '{id: 4'h2, addr: B + 32'h80, len: 8'd0, size: AXI_SIZE_WORD, burst: 2'b01};
    req.ar_valid = 1'b1;
    n_tests++;
    if (rsp.w_ready !== 1'b1 || rsp.ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_ready: w_ready=%b ar_ready=%b required 1 1", rsp.w_ready, rsp.ar_ready);
    end
    step();
    req.w_valid = 1'b0;
    req.ar_valid = 1'b0;
    n_tests++;
    if (rsp.r_valid !== 1'b1 || rsp.r.data !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rbw_old: valid=%b data=%h required 1 0badf00d", rsp.r_valid, rsp.r.data);
    end
    recv_r(r);
    recv_b(b);
    send_aw(4'h3, B + 32'h84, 8'd0, AXI_SIZE_WORD);
    send_w(32'h1357_9BDF, 4'hF, 1'b1);
    send_ar(4'h2, B + 32'h84, 8'd0, AXI_SIZE_WORD);
    recv_r(r);
    n_tests++;
    if (r.data !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL write_visible: data=%h required 13579bdf", r.data);
    end
    recv_b(b);
    n_tests++;
    if (b.resp !== AXI_RESP_OKAY || b.id !== 4'h3) begin
      n_fail++;
      $display("FAIL visible_b: id=%h resp=%b required 3 00", b.id, b.resp);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_strobes();
    test_out_of_range();
    test_protocol();
    test_reset_mid();
    test_concurrent();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
